// File: rtl/dram_seq_pkg.sv
// Shared definitions for the DRAM address sequencer: FSM state encoding,
// phase-counter sizing and elaboration-time parameter legality.
package dram_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RAS  = 3'd1,
    ST_COL  = 3'd2,
    ST_PRE  = 3'd3,
    ST_REF  = 3'd4
  } state_e;

  // Bits needed to count 0..max(a,b,c)-1, never less than one.
  function automatic int phase_w(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return (m <= 1) ? 1 : $clog2(m);
  endfunction

  function automatic bit params_legal(input int row_w, input int ras, input int cas,
                                      input int pre, input int intvl);
    return (row_w >= 1) && (ras >= 1) && (cas >= 1) && (pre >= 1) &&
           (intvl >= ras + pre + 1);
  endfunction

endpackage

// File: rtl/dram_refresh_timer.sv
// Refresh interval counter, single-deep pending flag and RAS-only refresh row
// counter for dram_addr_seq (present only when CADR_DRAM_REFRESH_EN is defined).
module dram_refresh_timer
  import dram_seq_pkg::*;
#(
  parameter int ROW_W     = 8,
  parameter int REF_INTVL = 390
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             ref_start,
  input  logic             ref_done,
  output logic             pending,
  output logic [ROW_W-1:0] refresh_row
);

  localparam int               INT_W    = (REF_INTVL <= 2) ? 1 : $clog2(REF_INTVL);
  localparam logic [INT_W-1:0] INT_LAST = INT_W'(REF_INTVL - 1);
  localparam logic [INT_W-1:0] INT_ONE  = INT_W'(1);
  localparam logic [ROW_W-1:0] ROW_ONE  = ROW_W'(1);

  logic [INT_W-1:0] intvl_r;
  logic             pending_r;
  logic [ROW_W-1:0] row_r;
  logic             wrap_s;

  assign wrap_s      = (intvl_r == INT_LAST);
  assign pending     = pending_r;
  assign refresh_row = row_r;

  // Free-running interval, pending flag (a wrap beats a same-cycle clear), row advance.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      intvl_r   <= '0;
      pending_r <= 1'b0;
      row_r     <= '0;
    end else begin
      intvl_r <= wrap_s ? '0 : intvl_r + INT_ONE;
      if (wrap_s) begin
        pending_r <= 1'b1;
      end else if (ref_start) begin
        pending_r <= 1'b0;
      end
      if (ref_done) begin
        row_r <= row_r + ROW_ONE;
      end
    end
  end

endmodule

// File: rtl/dram_addr_seq.sv
// Row/column address sequencer for one DRAM bank behind an inverting 74S258 mux.
// Define CADR_DRAM_REFRESH_EN to build in the RAS-only refresh timer and REF state.
module dram_addr_seq
  import dram_seq_pkg::*;
#(
  parameter int ROW_W     = 8,
  parameter int RAS_CYC   = 2,
  parameter int CAS_CYC   = 2,
  parameter int PRE_CYC   = 2,
  parameter int REF_INTVL = 390
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               req,
  input  logic               wr,
  input  logic [2*ROW_W-1:0] addr,
  output logic               ack,
  output logic               busy,
  output logic [ROW_W-1:0]   row_n,
  output logic [ROW_W-1:0]   col_n,
  output logic               mux_sel,
  output logic               mux_enb_n,
  output logic               ras_n,
  output logic               cas_n,
  output logic               we_n,
  output logic               ref_active
);

  localparam int               CNT_W    = phase_w(RAS_CYC, CAS_CYC, PRE_CYC);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] RAS_LAST = CNT_W'(RAS_CYC - 1);
  localparam logic [CNT_W-1:0] CAS_LAST = CNT_W'(CAS_CYC - 1);
  localparam logic [CNT_W-1:0] PRE_LAST = CNT_W'(PRE_CYC - 1);

  if (!params_legal(ROW_W, RAS_CYC, CAS_CYC, PRE_CYC, REF_INTVL)) begin : g_bad_params
    $error("dram_addr_seq: illegal timing parameters");
  end

  state_e           state_r, next_state_s;
  logic [CNT_W-1:0] cnt_r, next_cnt_s;
  logic [ROW_W-1:0] row_n_r, col_n_r, refresh_row_s;
  logic             wr_r, pending_s, accept_s, ref_start_s;
  logic             ack_r, busy_r, mux_sel_r, mux_enb_n_r, ras_n_r, cas_n_r, we_n_r, ref_active_r;
  logic             ack_s, busy_s, mux_sel_s, mux_enb_n_s, ras_n_s, cas_n_s, we_n_s, ref_active_s;

  assign accept_s    = (state_r == ST_IDLE) && (next_state_s == ST_RAS);
  assign ref_start_s = (state_r == ST_IDLE) && (next_state_s == ST_REF);

`ifdef CADR_DRAM_REFRESH_EN
  logic ref_done_s;
  assign ref_done_s = (state_r == ST_REF) && (next_state_s != ST_REF);

  dram_refresh_timer #(
    .ROW_W     (ROW_W),
    .REF_INTVL (REF_INTVL)
  ) u_refresh_timer (
    .clk         (clk),
    .reset_n     (reset_n),
    .ref_start   (ref_start_s),
    .ref_done    (ref_done_s),
    .pending     (pending_s),
    .refresh_row (refresh_row_s)
  );
`else
  assign pending_s     = 1'b0;
  assign refresh_row_s = '0;
`endif

  // Next state; refresh takes priority over a request, and only from IDLE.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (pending_s)  next_state_s = ST_REF;
        else if (req)   next_state_s = ST_RAS;
        else            next_state_s = ST_IDLE;
      end
      ST_RAS:  next_state_s = (cnt_r == RAS_LAST) ? ST_COL : ST_RAS;
      ST_COL:  next_state_s = (cnt_r == CAS_LAST) ? ST_PRE : ST_COL;
      ST_PRE:  next_state_s = (cnt_r == PRE_LAST) ? ST_IDLE : ST_PRE;
      ST_REF:  next_state_s = (cnt_r == RAS_LAST) ? ST_PRE : ST_REF;
      default: next_state_s = ST_IDLE;
    endcase
    next_cnt_s = (next_state_s != state_r) ? '0 : cnt_r + CNT_ONE;
  end

  // Outputs are decoded from the upcoming state so they change on the entry edge.
  always_comb begin
    ack_s        = 1'b0;
    busy_s       = 1'b1;
    mux_sel_s    = 1'b0;
    mux_enb_n_s  = 1'b1;
    ras_n_s      = 1'b1;
    cas_n_s      = 1'b1;
    we_n_s       = 1'b1;
    ref_active_s = 1'b0;
    case (next_state_s)
      ST_IDLE: busy_s = 1'b0;
      ST_RAS: begin
        mux_enb_n_s = 1'b0;
        ras_n_s     = 1'b0;
      end
      ST_COL: begin
        mux_sel_s   = 1'b1;
        mux_enb_n_s = 1'b0;
        ras_n_s     = 1'b0;
        cas_n_s     = 1'b0;
        we_n_s      = ~wr_r;
        ack_s       = (next_cnt_s == CAS_LAST);
      end
      ST_PRE:  busy_s = 1'b1;
      ST_REF: begin
        mux_enb_n_s  = 1'b0;
        ras_n_s      = 1'b0;
        ref_active_s = 1'b1;
      end
      default: busy_s = 1'b0;
    endcase
  end

  // State register, phase counter, address/WR latches and output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r      <= ST_IDLE;
      cnt_r        <= '0;
      wr_r         <= 1'b0;
      row_n_r      <= '1;
      col_n_r      <= '1;
      ack_r        <= 1'b0;
      busy_r       <= 1'b0;
      mux_sel_r    <= 1'b0;
      mux_enb_n_r  <= 1'b1;
      ras_n_r      <= 1'b1;
      cas_n_r      <= 1'b1;
      we_n_r       <= 1'b1;
      ref_active_r <= 1'b0;
    end else begin
      state_r      <= next_state_s;
      cnt_r        <= next_cnt_s;
      ack_r        <= ack_s;
      busy_r       <= busy_s;
      mux_sel_r    <= mux_sel_s;
      mux_enb_n_r  <= mux_enb_n_s;
      ras_n_r      <= ras_n_s;
      cas_n_r      <= cas_n_s;
      we_n_r       <= we_n_s;
      ref_active_r <= ref_active_s;
      if (accept_s) begin
        row_n_r <= ~addr[2*ROW_W-1:ROW_W];
        col_n_r <= ~addr[ROW_W-1:0];
        wr_r    <= wr;
      end else if (ref_start_s) begin
        row_n_r <= ~refresh_row_s;
      end
    end
  end

  assign ack        = ack_r;
  assign busy       = busy_r;
  assign row_n      = row_n_r;
  assign col_n      = col_n_r;
  assign mux_sel    = mux_sel_r;
  assign mux_enb_n  = mux_enb_n_r;
  assign ras_n      = ras_n_r;
  assign cas_n      = cas_n_r;
  assign we_n       = we_n_r;
  assign ref_active = ref_active_r;

endmodule
